hicore_hpm_csr: RTL and testbench

Parametrised hardware-performance-monitor CSR bank: NUM_CNT event counters (mhpmcounter3..), their event selectors (mhpmevent3..) and mcountinhibit. It generalises the core CSR unit's fixed mcycle/minstret pair to counters of configurable number and width, selectable events and inhibit control. It sits beside the core CSR unit on the same issue/write-back/commit interfaces:
- reads and read-modify-write data are computed at issue and returned one cycle later to the ROB;
- architectural writes happen only at commit.

---
 rtl/hicore_hpm_csr_pkg.sv | 35 +++
 rtl/hicore_hpm_csr_if.sv | 37 +++
 rtl/hicore_hpm_cnt.sv | 37 +++
 rtl/hicore_hpm_csr.sv | 145 ++++++++++++++
 tb/tb_hicore_hpm_csr.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hicore_hpm_csr_pkg.sv
// Shared definitions for the HPM CSR bank: CSR indices, issue_msg op encodings
// and the write/set/clear data function shared with the core CSR unit.
package hicore_hpm_csr_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_MHPMOVF       = 12'h7C0;

    // First hpm index; counter k lives at bit/offset HPM_BASE + k.
    localparam int HPM_BASE = 3;

    // issue_msg[1:0] carries the op; issue_msg[2] only distinguishes rs1/uimm.
    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_wdata(input logic [2:0]  msg,
                                              input logic [31:0] rdata,
                                              input logic [31:0] src);
        logic [31:0] result;
        case (csr_op_e'(msg[1:0]))
            CSR_OP_WRITE: result = src;
            CSR_OP_SET:   result = rdata | src;
            CSR_OP_CLEAR: result = rdata & ~src;
            default:      result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hicore_hpm_csr_if.sv
// Issue / write-back / commit bundle between the pipeline and the HPM CSR bank.
interface hicore_hpm_csr_if #(
    parameter int ROB_PTR_W = 4
) ();

    logic                 issue_valid;
    logic                 issue_ready;
    logic                 issue_cancel;
    logic [11:0]          issue_idx;
    logic [2:0]           issue_msg;
    logic [31:0]          issue_src;
    logic [ROB_PTR_W-1:0] issue_ptr;

    logic                 wb_wen;
    logic [ROB_PTR_W-1:0] wb_ptr;
    logic [31:0]          wb_rd_data;
    logic [31:0]          wb_csr_data;

    logic                 commit_valid;
    logic                 commit_excp;
    logic                 commit_csr_need;
    logic [11:0]          commit_csr_idx;
    logic [31:0]          commit_csr_data;

    modport master (
        output issue_valid, issue_cancel, issue_idx, issue_msg, issue_src, issue_ptr,
        output commit_valid, commit_excp, commit_csr_need, commit_csr_idx, commit_csr_data,
        input  issue_ready, wb_wen, wb_ptr, wb_rd_data, wb_csr_data
    );

    modport slave (
        input  issue_valid, issue_cancel, issue_idx, issue_msg, issue_src, issue_ptr,
        input  commit_valid, commit_excp, commit_csr_need, commit_csr_idx, commit_csr_data,
        output issue_ready, wb_wen, wb_ptr, wb_rd_data, wb_csr_data
    );

endinterface

// File: rtl/hicore_hpm_cnt.sv
// One CNT_W-bit performance counter with split low/high write ports.
// A write in the same cycle as an increment wins and suppresses the increment.
module hicore_hpm_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      data,
    output logic [CNT_W-1:0] value,
    output logic             wrap
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr_lo) begin
            cnt_q[31:0] <= data;
        end else if (wr_hi) begin
            cnt_q[CNT_W-1:32] <= data[HI_W-1:0];
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign value = cnt_q;
    assign wrap  = inc & ~wr_lo & ~wr_hi & (&cnt_q);

endmodule

// File: rtl/hicore_hpm_csr.sv
// HPM CSR bank: NUM_CNT event counters, selectors and mcountinhibit.
// Define HICORE_HPM_OVF_IRQ_EN for sticky overflow bits at 0x7C0 and ovf_irq.
module hicore_hpm_csr
    import hicore_hpm_csr_pkg::*;
#(
    parameter int NUM_CNT   = 4,
    parameter int CNT_W     = 64,
    parameter int NUM_EVT   = 8,
    parameter int ROB_PTR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               flush,
    output logic               ovf_irq,
    hicore_hpm_csr_if.slave    bus
);

    localparam int SEL_W = $clog2(NUM_EVT + 1);
    localparam logic [SEL_W-1:0] EVT_MAX = SEL_W'(NUM_EVT);

    logic [NUM_CNT-1:0] inh_q;
    logic [SEL_W-1:0]   sel_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_wr_lo;
    logic [NUM_CNT-1:0] cnt_wr_hi;
    logic [NUM_CNT-1:0] cnt_wrap;
    logic [NUM_EVT:0]   evt_ext;
    logic               wr_en;
    logic [31:0]        rdata;
    logic [31:0]        ovf_rd;

    assign wr_en   = bus.commit_valid & bus.commit_csr_need & ~bus.commit_excp;
    // Bit 0 stands for selector 0 (no event), so the selector indexes directly.
    assign evt_ext = {evt_i, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inh_q <= '0;
            for (int k = 0; k < NUM_CNT; k++) sel_q[k] <= '0;
        end else if (wr_en) begin
            if (bus.commit_csr_idx == CSR_MCOUNTINHIBIT)
                inh_q <= bus.commit_csr_data[HPM_BASE +: NUM_CNT];
            for (int k = 0; k < NUM_CNT; k++)
                if (bus.commit_csr_idx == CSR_MHPMEVENT3 + 12'(k))
                    sel_q[k] <= bus.commit_csr_data[SEL_W-1:0];
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        logic evt_hit;
        assign evt_hit      = (sel_q[k] <= EVT_MAX) ? evt_ext[sel_q[k]] : 1'b0;
        assign cnt_inc[k]   = evt_hit & ~inh_q[k];
        assign cnt_wr_lo[k] = wr_en && (bus.commit_csr_idx == CSR_MHPMCOUNTER3 + 12'(k));
        assign cnt_wr_hi[k] = wr_en && (bus.commit_csr_idx == CSR_MHPMCOUNTER3H + 12'(k));

        hicore_hpm_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[k]),
            .wr_lo (cnt_wr_lo[k]),
            .wr_hi (cnt_wr_hi[k]),
            .data  (bus.commit_csr_data),
            .value (cnt_val[k]),
            .wrap  (cnt_wrap[k])
        );
    end

`ifdef HICORE_HPM_OVF_IRQ_EN
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_clr;
    logic [NUM_CNT-1:0] ovf_next;
    logic               ovf_irq_q;

    assign ovf_clr  = (wr_en && bus.commit_csr_idx == CSR_MHPMOVF)
                    ? bus.commit_csr_data[HPM_BASE +: NUM_CNT] : '0;
    // A wrap in the clearing cycle keeps its bit set.
    assign ovf_next = (ovf_q & ~ovf_clr) | cnt_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_next;
            ovf_irq_q <= |ovf_next;
        end
    end

    assign ovf_rd  = 32'(ovf_q) << HPM_BASE;
    assign ovf_irq = ovf_irq_q;
`else
    logic unused_wrap;
    assign unused_wrap = |cnt_wrap;
    assign ovf_rd      = '0;
    assign ovf_irq     = 1'b0;
`endif

    // NOTE: rdata gets a default before the decode so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        if (bus.issue_idx == CSR_MCOUNTINHIBIT) rdata = 32'(inh_q) << HPM_BASE;
        if (bus.issue_idx == CSR_MHPMOVF)       rdata = ovf_rd;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (bus.issue_idx == CSR_MHPMEVENT3 + 12'(k))    rdata = 32'(sel_q[k]);
            if (bus.issue_idx == CSR_MHPMCOUNTER3 + 12'(k))  rdata = cnt_val[k][31:0];
            if (bus.issue_idx == CSR_MHPMCOUNTER3H + 12'(k)) rdata = 32'(cnt_val[k][CNT_W-1:32]);
        end
    end

    logic                 stage_valid_q;
    logic                 stage_cancel_q;
    logic [ROB_PTR_W-1:0] stage_ptr_q;
    logic [31:0]          stage_rd_q;
    logic [31:0]          stage_wd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid_q  <= 1'b0;
            stage_cancel_q <= 1'b0;
        end else begin
            stage_valid_q  <= bus.issue_valid & ~flush;
            stage_cancel_q <= bus.issue_cancel;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while
    // stage_valid_q, which is reset, qualifies them.
    always_ff @(posedge clk) begin
        if (bus.issue_valid) begin
            stage_ptr_q <= bus.issue_ptr;
            stage_rd_q  <= rdata;
            stage_wd_q  <= csr_wdata(bus.issue_msg, rdata, bus.issue_src);
        end
    end

    assign bus.issue_ready = 1'b1;
    assign bus.wb_wen      = stage_valid_q & ~stage_cancel_q & ~flush;
    assign bus.wb_ptr      = stage_ptr_q;
    assign bus.wb_rd_data  = stage_rd_q;
    assign bus.wb_csr_data = stage_wd_q;

endmodule

// File: tb/tb_hicore_hpm_csr.sv
// Directed bench for hicore_hpm_csr (NUM_CNT=4, CNT_W=40, NUM_EVT=8); expectations
// follow HICORE_HPM_OVF_IRQ_EN when it is defined for the build.
module tb_hicore_hpm_csr;

    localparam int NUM_CNT   = 4;
    localparam int CNT_W     = 40;
    localparam int NUM_EVT   = 8;
    localparam int ROB_PTR_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_EVT-1:0] evt_i = '0;
    logic               flush = 1'b0;
    logic               ovf_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hicore_hpm_csr_if #(.ROB_PTR_W(ROB_PTR_W)) bus ();

    hicore_hpm_csr #(
        .NUM_CNT   (NUM_CNT),
        .CNT_W     (CNT_W),
        .NUM_EVT   (NUM_EVT),
        .ROB_PTR_W (ROB_PTR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .evt_i   (evt_i),
        .flush   (flush),
        .ovf_irq (ovf_irq),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid     = 1'b0;
        bus.issue_cancel    = 1'b0;
        bus.issue_idx       = '0;
        bus.issue_msg       = '0;
        bus.issue_src       = '0;
        bus.issue_ptr       = '0;
        bus.commit_valid    = 1'b0;
        bus.commit_excp     = 1'b0;
        bus.commit_csr_need = 1'b0;
        bus.commit_csr_idx  = '0;
        bus.commit_csr_data = '0;
    endtask

    task automatic commit_wr(input logic [11:0] idx, input logic [31:0] data);
        @(negedge clk);
        bus.commit_valid    = 1'b1;
        bus.commit_csr_need = 1'b1;
        bus.commit_csr_idx  = idx;
        bus.commit_csr_data = data;
        @(negedge clk);
        idle();
    endtask

    // Issue for one cycle; on return the write-back stage holds the result.
    task automatic issue_op(input logic [11:0] idx, input logic [2:0] msg,
                            input logic [31:0] src, input logic [ROB_PTR_W-1:0] ptr);
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_idx   = idx;
        bus.issue_msg   = msg;
        bus.issue_src   = src;
        bus.issue_ptr   = ptr;
        @(negedge clk);
        idle();
    endtask

    task automatic read_csr(input string tag, input logic [11:0] idx, input logic [31:0] exp);
        issue_op(idx, 3'b000, 32'h0, 4'h3);
        check(tag, bus.wb_rd_data, exp);
    endtask

    task automatic pulse(input logic [NUM_EVT-1:0] mask, input int n);
        @(negedge clk);
        evt_i = mask;
        repeat (n) @(negedge clk);
        evt_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // An op issued while reset is held must never reach write-back.
        bus.issue_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.wb_wen", 32'(bus.wb_wen), 32'h0);
        check("reset.ovf_irq", 32'(ovf_irq), 32'h0);
        check("reset.issue_ready", 32'(bus.issue_ready), 32'h1);
        idle();
        rst_n = 1'b1;

        read_csr("map.inhibit", 12'h320, 32'h0);
        read_csr("map.ovf", 12'h7C0, 32'h0);
        for (int k = 0; k <= NUM_CNT; k++) begin
            read_csr($sformatf("map.event%0d", k), 12'h323 + 12'(k), 32'h0);
            read_csr($sformatf("map.cnt_lo%0d", k), 12'hB03 + 12'(k), 32'h0);
            read_csr($sformatf("map.cnt_hi%0d", k), 12'hB83 + 12'(k), 32'h0);
        end

        // Counting and inhibit on counter 0.
        commit_wr(12'h323, 32'h1);
        read_csr("sel0.readback", 12'h323, 32'h1);
        pulse(8'h01, 5);
        read_csr("count.5", 12'hB03, 32'h5);
        commit_wr(12'h320, 32'hFFFF_FFFF);
        read_csr("inhibit.mask", 12'h320, 32'h0000_0078);
        pulse(8'h01, 3);
        read_csr("inhibit.hold", 12'hB03, 32'h5);
        commit_wr(12'h320, 32'h0);

        // Carry into the high half, high-write masking, then full wrap.
        commit_wr(12'hB03, 32'hFFFF_FFFF);
        pulse(8'h01, 1);
        read_csr("carry.lo", 12'hB03, 32'h0);
        read_csr("carry.hi", 12'hB83, 32'h1);
        commit_wr(12'hB83, 32'hFFFF_FF12);
        read_csr("hi.mask", 12'hB83, 32'h12);
        commit_wr(12'hB83, 32'hFF);
        commit_wr(12'hB03, 32'hFFFF_FFFF);
        read_csr("pre_wrap.ovf", 12'h7C0, 32'h0);
        pulse(8'h01, 1);
        read_csr("wrap.lo", 12'hB03, 32'h0);
        read_csr("wrap.hi", 12'hB83, 32'h0);
`ifdef HICORE_HPM_OVF_IRQ_EN
        read_csr("wrap.ovf_bit", 12'h7C0, 32'h8);
        check("wrap.ovf_irq", 32'(ovf_irq), 32'h1);
        commit_wr(12'h7C0, 32'h8);
        read_csr("ovf.cleared", 12'h7C0, 32'h0);
        check("ovf.irq_cleared", 32'(ovf_irq), 32'h0);
`else
        read_csr("wrap.ovf_bit", 12'h7C0, 32'h0);
        check("wrap.ovf_irq", 32'(ovf_irq), 32'h0);
        commit_wr(12'h7C0, 32'hFFFF_FFFF);
        read_csr("ovf.ignored", 12'h7C0, 32'h0);
`endif

        // Selector range: 9 > NUM_EVT acts as no event, 8 picks evt_i[7].
        commit_wr(12'h324, 32'h9);
        commit_wr(12'h325, 32'h8);
        pulse(8'hFF, 2);
        read_csr("sel.cnt0", 12'hB03, 32'h2);
        read_csr("sel.over_max", 12'hB04, 32'h0);
        read_csr("sel.top_evt", 12'hB05, 32'h2);
        read_csr("sel.none", 12'hB06, 32'h0);
        commit_wr(12'h327, 32'h5);
        read_csr("oob.event", 12'h327, 32'h0);
        commit_wr(12'hB07, 32'h5);
        read_csr("oob.cnt", 12'hB07, 32'h0);

        // Commit write colliding with an event and with an issue read.
        commit_wr(12'hB03, 32'h7);
        @(negedge clk);
        bus.commit_valid    = 1'b1;
        bus.commit_csr_need = 1'b1;
        bus.commit_csr_idx  = 12'hB03;
        bus.commit_csr_data = 32'h10;
        bus.issue_valid     = 1'b1;
        bus.issue_idx       = 12'hB03;
        bus.issue_ptr       = 4'h5;
        evt_i               = 8'h01;
        @(negedge clk);
        idle();
        evt_i = '0;
        check("collide.old_rd", bus.wb_rd_data, 32'h7);
        check("collide.ptr", 32'(bus.wb_ptr), 32'h5);
        read_csr("collide.lo_wins", 12'hB03, 32'h10);
        commit_wr(12'hB03, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.commit_valid    = 1'b1;
        bus.commit_csr_need = 1'b1;
        bus.commit_csr_idx  = 12'hB83;
        bus.commit_csr_data = 32'h3;
        evt_i               = 8'h01;
        @(negedge clk);
        idle();
        evt_i = '0;
        read_csr("collide.hi_wins", 12'hB83, 32'h3);
        read_csr("collide.hi_no_inc", 12'hB03, 32'hFFFF_FFFF);

        // Read-modify-write data on mcountinhibit.
        issue_op(12'h320, 3'b010, 32'h18, 4'h9);
        check("set.wen", 32'(bus.wb_wen), 32'h1);
        check("set.csr_data", bus.wb_csr_data, 32'h18);
        check("set.rd", bus.wb_rd_data, 32'h0);
        check("set.ptr", 32'(bus.wb_ptr), 32'h9);
        commit_wr(12'h320, 32'h18);
        issue_op(12'h320, 3'b011, 32'h08, 4'h2);
        check("clear.csr_data", bus.wb_csr_data, 32'h10);
        check("clear.rd", bus.wb_rd_data, 32'h18);
        issue_op(12'h320, 3'b101, 32'hABCD, 4'h1);
        check("write.csr_data", bus.wb_csr_data, 32'hABCD);
        issue_op(12'h320, 3'b100, 32'hFF, 4'h0);
        check("read.csr_data", bus.wb_csr_data, 32'h0);
        commit_wr(12'h320, 32'h0);

        // Cancel, flush and exception.
        @(negedge clk);
        bus.issue_valid  = 1'b1;
        bus.issue_cancel = 1'b1;
        bus.issue_idx    = 12'hB03;
        @(negedge clk);
        idle();
        check("cancel.wen", 32'(bus.wb_wen), 32'h0);
        issue_op(12'hB03, 3'b000, 32'h0, 4'h4);
        check("flush.pre_wen", 32'(bus.wb_wen), 32'h1);
        flush = 1'b1;
        #1;
        check("flush.wen", 32'(bus.wb_wen), 32'h0);
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_idx   = 12'hB03;
        @(negedge clk);
        idle();
        flush = 1'b0;
        check("flush.dropped", 32'(bus.wb_wen), 32'h0);
        @(negedge clk);
        bus.commit_valid    = 1'b1;
        bus.commit_csr_need = 1'b1;
        bus.commit_excp     = 1'b1;
        bus.commit_csr_idx  = 12'hB03;
        bus.commit_csr_data = 32'h55;
        @(negedge clk);
        bus.commit_excp     = 1'b0;
        bus.commit_csr_need = 1'b0;
        @(negedge clk);
        idle();
        read_csr("excp.unchanged", 12'hB03, 32'hFFFF_FFFF);

        // Reset arriving with a write-back pending.
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_idx   = 12'hB03;
        rst_n           = 1'b0;
        @(negedge clk);
        idle();
        check("rst_mid.wen", 32'(bus.wb_wen), 32'h0);
        rst_n = 1'b1;
        read_csr("rst_mid.cnt", 12'hB03, 32'h0);
        read_csr("rst_mid.sel", 12'h323, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
